// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and default widths for the
// iterative multiply/divide writeback unit. Rev 1.0
`default_nettype none

package muldiv_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } state_t;

  // DIV/REM share the divider; MULH/REM take the upper half of the accumulator.
  function automatic logic op_is_div(input logic [1:0] i_op);
    return i_op[1];
  endfunction

  function automatic logic op_is_high(input logic [1:0] i_op);
    return i_op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or
// restoring divide on a shared 2*DATA_WIDTH+1 bit accumulator. Rev 1.0
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    i_is_div,
  input  logic [2*DATA_WIDTH:0]   i_acc,
  input  logic [DATA_WIDTH-1:0]   i_operand_b,
  output logic [2*DATA_WIDTH:0]   o_acc
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   w_sum;
  logic [W+1:0] w_shifted;
  logic [W+1:0] w_diff;

  // Divide layout: {remainder[W:0], quotient[W-1:0]}; multiply uses the low 2W bits.
  always_comb begin
    w_sum     = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_operand_b} : '0);
    w_shifted = {i_acc[2*W:W], i_acc[W-1]};
    w_diff    = w_shifted - {2'b00, i_operand_b};
    if (i_is_div) begin
      if (w_diff[W+1]) begin
        o_acc = {w_shifted[W:0], i_acc[W-2:0], 1'b0};
      end else begin
        o_acc = {w_diff[W:0], i_acc[W-2:0], 1'b1};
      end
    end else begin
      o_acc = {1'b0, w_sum, i_acc[W-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_writeback_unit.sv
// muldiv_writeback_unit: fixed-latency unsigned MUL/MULH/DIV/REM unit that
// drives the register file write port directly. Rev 1.0
`default_nettype none

module muldiv_writeback_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [ADDR_WIDTH-1:0] dest_reg,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  reg_write
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_count;
  logic [2*W:0]          r_acc;
  logic [2*W:0]          w_acc_next;
  logic [W-1:0]          r_operand_b;
  logic                  r_is_div;
  logic                  r_is_high;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [ADDR_WIDTH-1:0] r_write_reg;
  logic [W-1:0]          r_write_data;
  logic                  r_reg_write;
  logic                  w_last;

  muldiv_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_is_div    (r_is_div),
    .i_acc       (r_acc),
    .i_operand_b (r_operand_b),
    .o_acc       (w_acc_next)
  );

  assign w_last = (r_count == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_acc        <= '0;
      r_operand_b  <= '0;
      r_is_div     <= 1'b0;
      r_is_high    <= 1'b0;
      r_dest       <= '0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_reg_write  <= 1'b0;
    end else begin
      r_reg_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc       <= {{(W+1){1'b0}}, operand_a};
            r_operand_b <= operand_b;
            r_is_div    <= op_is_div(op);
            r_is_high   <= op_is_high(op);
            r_dest      <= dest_reg;
            r_count     <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CW'(1);
          // Result is registered straight from the final iteration so WB needs no extra cycle.
          if (w_last) begin
            r_write_reg  <= r_dest;
            r_write_data <= r_is_high ? w_acc_next[2*W-1:W] : w_acc_next[W-1:0];
            r_reg_write  <= (r_dest != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign reg_write  = r_reg_write;

endmodule

`default_nettype wire
